// File: rtl/mem_port_responder.sv
// ============================================================================
// Module   : mem_port_responder
// Brief    : MemPortIo responder serving one core port from a private word
//            scratchpad. Define MEM_MISALIGN_CHECK_EN to add misalignment checks.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_responder #(
    parameter int DEPTH_WORDS = 4096,
    parameter int LATENCY     = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_data,
    input  logic        req_fcn,
    input  logic [2:0]  req_typ,
    output logic        resp_valid,
    output logic [31:0] resp_data
`ifdef MEM_MISALIGN_CHECK_EN
    ,
    output logic        resp_misaligned
`endif
);

    localparam int c_aw = $clog2(DEPTH_WORDS);
    localparam int c_cw = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;

    localparam logic [2:0] c_mt_b  = 3'd1;
    localparam logic [2:0] c_mt_h  = 3'd2;
    localparam logic [2:0] c_mt_bu = 3'd5;
    localparam logic [2:0] c_mt_hu = 3'd6;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [c_cw-1:0]   r_count, w_count_nxt;
    logic              w_accept;
    logic [c_aw-1:0]   w_idx;
    logic              w_is_byte, w_is_half, w_is_uns;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata;
    logic              w_unused_addr;

    logic [31:0]       r_mem [DEPTH_WORDS];
    logic [31:0]       r_word;
    logic              r_fcn, r_byte, r_half, r_uns;
    logic [1:0]        r_lane;
    logic [31:0]       r_last;
    logic [31:0]       w_result;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;

    assign req_ready     = (r_state != S_BUSY);
    assign w_accept      = req_valid & req_ready;
    assign w_idx         = req_addr[c_aw+1:2];
    assign w_unused_addr = ^req_addr[31:c_aw+2];

`ifdef MEM_MISALIGN_CHECK_EN
    logic w_mis;
    logic r_mis;
`endif

    // Request decode: illegal typ codes fall through to full-word access
    always_comb begin
        w_is_byte = (req_typ == c_mt_b) || (req_typ == c_mt_bu);
        w_is_half = (req_typ == c_mt_h) || (req_typ == c_mt_hu);
        w_is_uns  = (req_typ == c_mt_bu) || (req_typ == c_mt_hu);
        w_wdata   = req_data;
        w_be      = 4'b1111;
        if (w_is_byte) begin
            w_wdata = {4{req_data[7:0]}};
            w_be    = 4'b0001 << req_addr[1:0];
        end else if (w_is_half) begin
            w_wdata = {2{req_data[15:0]}};
            w_be    = req_addr[1] ? 4'b1100 : 4'b0011;
        end
`ifdef MEM_MISALIGN_CHECK_EN
        w_mis = (w_is_half & req_addr[0]) |
                (~w_is_byte & ~w_is_half & (req_addr[1:0] != 2'b00));
        if (w_mis) begin
            w_be = 4'b0000;
        end
`endif
    end

    // Scratchpad is not reset; the rst gate stops an accept during reset
    always_ff @(posedge clk) begin
        if (w_accept && !rst) begin
            if (req_fcn) begin
                for (int i = 0; i < 4; i++) begin
                    if (w_be[i]) begin
                        r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
                    end
                end
            end
            r_word <= r_mem[w_idx];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_fcn   <= 1'b0;
            r_byte  <= 1'b0;
            r_half  <= 1'b0;
            r_uns   <= 1'b0;
            r_lane  <= 2'b00;
            r_last  <= '0;
`ifdef MEM_MISALIGN_CHECK_EN
            r_mis   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            if (w_accept) begin
                r_fcn  <= req_fcn;
                r_byte <= w_is_byte;
                r_half <= w_is_half;
                r_uns  <= w_is_uns;
                r_lane <= req_addr[1:0];
`ifdef MEM_MISALIGN_CHECK_EN
                r_mis  <= w_mis;
`endif
            end
            if (r_state == S_RESP) begin
                r_last <= w_result;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        case (r_state)
            S_BUSY: begin
                if (r_count == '0) begin
                    w_state_nxt = S_RESP;
                end else begin
                    w_count_nxt = r_count - c_cw'(1);
                end
            end
            S_RESP:  w_state_nxt = S_IDLE;
            default: ;
        endcase
        // Accept is only possible in IDLE or RESP, so it overrides the above
        if (w_accept) begin
            if (LATENCY == 1) begin
                w_state_nxt = S_RESP;
            end else begin
                w_state_nxt = S_BUSY;
                w_count_nxt = c_cw'(LATENCY - 2);
            end
        end
    end

    always_comb begin
        w_byte   = r_word[{r_lane, 3'b000} +: 8];
        w_half   = r_word[{r_lane[1], 4'b0000} +: 16];
        w_result = r_word;
        if (r_byte) begin
            w_result = {{24{~r_uns & w_byte[7]}}, w_byte};
        end else if (r_half) begin
            w_result = {{16{~r_uns & w_half[15]}}, w_half};
        end
        if (r_fcn) begin
            w_result = '0;
        end
`ifdef MEM_MISALIGN_CHECK_EN
        if (r_mis) begin
            w_result = '0;
        end
`endif
    end

    assign resp_valid = (r_state == S_RESP);
    assign resp_data  = (r_state == S_RESP) ? w_result : r_last;

`ifdef MEM_MISALIGN_CHECK_EN
    assign resp_misaligned = (r_state == S_RESP) & r_mis;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_port_responder.sv
// ============================================================================
// Module   : tb_mem_port_responder
// Brief    : Scoreboard bench for mem_port_responder at LATENCY 1 and 3.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        sel = 1'b0;
    logic        req_fcn = 1'b0;
    logic [2:0]  req_typ = 3'd3;
    logic [31:0] req_addr = '0;
    logic [31:0] req_data = '0;

    logic        v1, v3, rdy;
    logic        ready1, rv1, ready3, rv3;
    logic [31:0] rd1, rd3;
    logic        mis1, mis3;

    always #5 clk = ~clk;

    assign v1  = req_valid & ~sel;
    assign v3  = req_valid & sel;
    assign rdy = sel ? ready3 : ready1;

    mem_port_responder #(.DEPTH_WORDS(4096), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .req_valid(v1), .req_ready(ready1),
        .req_addr(req_addr), .req_data(req_data), .req_fcn(req_fcn),
        .req_typ(req_typ), .resp_valid(rv1), .resp_data(rd1)
`ifdef MEM_MISALIGN_CHECK_EN
        , .resp_misaligned(mis1)
`endif
    );

    mem_port_responder #(.DEPTH_WORDS(256), .LATENCY(3)) dut3 (
        .clk(clk), .rst(rst), .req_valid(v3), .req_ready(ready3),
        .req_addr(req_addr), .req_data(req_data), .req_fcn(req_fcn),
        .req_typ(req_typ), .resp_valid(rv3), .resp_data(rd3)
`ifdef MEM_MISALIGN_CHECK_EN
        , .resp_misaligned(mis3)
`endif
    );

`ifndef MEM_MISALIGN_CHECK_EN
    assign mis1 = 1'b0;
    assign mis3 = 1'b0;
`endif

    typedef struct {
        logic [31:0] data;
        logic        mis;
        int          due;
        string       tag;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Response monitor: every strobe must match the oldest expectation
    exp_t        m_e;
    logic [31:0] m_data;
    logic        m_mis;
    always @(negedge clk) begin
        if (rv1 || rv3) begin
            m_data = rv3 ? rd3 : rd1;
            m_mis  = rv3 ? mis3 : mis1;
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: resp_valid at cycle %0d, required none", cyc);
            end else begin
                m_e = sbq.pop_front();
                checks++;
                if (m_data !== m_e.data) begin
                    errors++;
                    $display("FAIL %s data: got %h, required %h", m_e.tag, m_data, m_e.data);
                end
                checks++;
                if (cyc != m_e.due) begin
                    errors++;
                    $display("FAIL %s timing: resp at cycle %0d, required %0d", m_e.tag, cyc, m_e.due);
                end
`ifdef MEM_MISALIGN_CHECK_EN
                checks++;
                if (m_mis !== m_e.mis) begin
                    errors++;
                    $display("FAIL %s misaligned: got %b, required %b", m_e.tag, m_mis, m_e.mis);
                end
`endif
            end
        end
    end

    task automatic issue(input logic fcn, input logic [2:0] typ, input logic [31:0] addr,
                         input logic [31:0] data, input logic [31:0] exp_data,
                         input logic exp_mis, input string tag);
        exp_t e;
        int   waited = 0;
        req_valid = 1'b1;
        req_fcn   = fcn;
        req_typ   = typ;
        req_addr  = addr;
        req_data  = data;
        forever begin
            @(negedge clk);
            if (rdy) break;
            waited++;
            if (waited > 50) begin
                checks++;
                errors++;
                $display("FAIL %s accept: req_ready stayed %b, required 1", tag, rdy);
                req_valid = 1'b0;
                return;
            end
        end
        e.data = exp_data;
        e.mis  = exp_mis;
        e.due  = cyc + (sel ? 3 : 1);
        e.tag  = tag;
        sbq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        req_valid = 1'b0;
        for (int i = 0; i < 20 && sbq.size() != 0; i++) @(posedge clk);
        #1;
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d responses outstanding, required 0", sbq.size());
            sbq.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (ready1 !== 1'b1 || ready3 !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b/%b, required 1/1", ready1, ready3);
        end
        checks++;
        if (rv1 !== 1'b0 || rv3 !== 1'b0 || mis1 !== 1'b0 || mis3 !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: got %b/%b mis %b/%b, required 0", rv1, rv3, mis1, mis3);
        end
        checks++;
        if (rd1 !== 32'h0 || rd3 !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: got %h/%h, required 0", rd1, rd3);
        end
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (ready1 !== 1'b1 || rv1 !== 1'b0 || rd1 !== 32'h0) begin
            errors++;
            $display("FAIL idle: got ready %b valid %b data %h, required 1 0 0", ready1, rv1, rd1);
        end
    endtask

    task automatic test_word();
        sel = 1'b0;
        issue(1'b1, 3'd3, 32'h100, 32'hDEADBEEF, 32'h0, 1'b0, "st_w");
        issue(1'b0, 3'd3, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, "ld_w");
        drain();
    endtask

    task automatic test_byte();
        sel = 1'b0;
        issue(1'b1, 3'd3, 32'h100, 32'h0, 32'h0, 1'b0, "st_w_clr");
        issue(1'b1, 3'd1, 32'h101, 32'h12345680, 32'h0, 1'b0, "st_b");
        issue(1'b0, 3'd1, 32'h101, 32'h0, 32'hFFFFFF80, 1'b0, "ld_b");
        issue(1'b0, 3'd5, 32'h101, 32'h0, 32'h00000080, 1'b0, "ld_bu");
        issue(1'b0, 3'd3, 32'h100, 32'h0, 32'h00008000, 1'b0, "ld_w_after_b");
        issue(1'b0, 3'd1, 32'h100, 32'h0, 32'h00000000, 1'b0, "ld_b_lane0");
        drain();
    endtask

    task automatic test_half();
        sel = 1'b0;
        issue(1'b1, 3'd3, 32'h200, 32'h11223344, 32'h0, 1'b0, "st_w_h");
        issue(1'b1, 3'd2, 32'h202, 32'hABCD8001, 32'h0, 1'b0, "st_h");
        issue(1'b0, 3'd2, 32'h202, 32'h0, 32'hFFFF8001, 1'b0, "ld_h");
        issue(1'b0, 3'd6, 32'h202, 32'h0, 32'h00008001, 1'b0, "ld_hu");
        issue(1'b0, 3'd3, 32'h200, 32'h0, 32'h80013344, 1'b0, "ld_w_after_h");
        issue(1'b0, 3'd2, 32'h200, 32'h0, 32'h00003344, 1'b0, "ld_h_low");
        issue(1'b0, 3'd0, 32'h200, 32'h0, 32'h80013344, 1'b0, "ld_typ0");
        issue(1'b0, 3'd7, 32'h200, 32'h0, 32'h80013344, 1'b0, "ld_typ7");
        drain();
    endtask

    task automatic test_wrap();
        sel = 1'b0;
        issue(1'b1, 3'd3, 32'h00004010, 32'hCAFEF00D, 32'h0, 1'b0, "st_wrap");
        issue(1'b0, 3'd3, 32'h00000010, 32'h0, 32'hCAFEF00D, 1'b0, "ld_wrap_lo");
        issue(1'b0, 3'd3, 32'hFFFFC010, 32'h0, 32'hCAFEF00D, 1'b0, "ld_wrap_hi");
        drain();
    endtask

    task automatic test_back_to_back();
        int c0;
        sel = 1'b0;
        c0 = cyc;
        issue(1'b0, 3'd3, 32'h100, 32'h0, 32'h00008000, 1'b0, "b2b_0");
        issue(1'b0, 3'd5, 32'h101, 32'h0, 32'h00000080, 1'b0, "b2b_1");
        issue(1'b0, 3'd6, 32'h202, 32'h0, 32'h00008001, 1'b0, "b2b_2");
        issue(1'b0, 3'd3, 32'h010, 32'h0, 32'hCAFEF00D, 1'b0, "b2b_3");
        checks++;
        if (cyc - c0 != 4) begin
            errors++;
            $display("FAIL b2b_accepts: 4 accepts took %0d cycles, required 4", cyc - c0);
        end
        drain();
    endtask

    task automatic test_latency3();
        int c0;
        sel = 1'b1;
        issue(1'b1, 3'd3, 32'h0, 32'hA5A50001, 32'h0, 1'b0, "l3_st0");
        issue(1'b1, 3'd3, 32'h4, 32'h5A5A0002, 32'h0, 1'b0, "l3_st1");
        issue(1'b1, 3'd3, 32'h8, 32'h00000083, 32'h0, 1'b0, "l3_st2");
        issue(1'b1, 3'd3, 32'hC, 32'hFFFF7FFF, 32'h0, 1'b0, "l3_st3");
        drain();
        c0 = cyc;
        for (int i = 0; i < 4; i++) begin
            case (i)
                0:       issue(1'b0, 3'd3, 32'h0, 32'h0, 32'hA5A50001, 1'b0, "l3_ld0");
                1:       issue(1'b0, 3'd3, 32'h4, 32'h0, 32'h5A5A0002, 1'b0, "l3_ld1");
                2:       issue(1'b0, 3'd1, 32'h8, 32'h0, 32'hFFFFFF83, 1'b0, "l3_ld2");
                default: issue(1'b0, 3'd2, 32'hC, 32'h0, 32'h00007FFF, 1'b0, "l3_ld3");
            endcase
            checks++;
            if (ready3 !== 1'b0) begin
                errors++;
                $display("FAIL l3_busy_ready%0d: got %b, required 0", i, ready3);
            end
        end
        checks++;
        if (cyc - c0 != 10) begin
            errors++;
            $display("FAIL l3_accept_spacing: 4 accepts took %0d cycles, required 10", cyc - c0);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        sel = 1'b1;
        issue(1'b1, 3'd3, 32'h10, 32'h13579BDF, 32'h0, 1'b0, "mid_st");
        req_valid = 1'b0;
        #2;
        rst = 1'b1;
        sbq.delete();
        #1;
        checks++;
        if (ready3 !== 1'b1 || rv3 !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got ready %b valid %b, required 1 0", ready3, rv3);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        issue(1'b0, 3'd3, 32'h10, 32'h0, 32'h13579BDF, 1'b0, "mid_st_kept");
        drain();
    endtask

    task automatic test_misalign();
        sel = 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
        issue(1'b1, 3'd3, 32'h103, 32'h12345678, 32'h0, 1'b1, "mis_st_w");
        issue(1'b0, 3'd3, 32'h100, 32'h0, 32'h00008000, 1'b0, "mis_mem_kept");
        issue(1'b0, 3'd3, 32'h103, 32'h0, 32'h0, 1'b1, "mis_ld_w");
        issue(1'b0, 3'd2, 32'h203, 32'h0, 32'h0, 1'b1, "mis_ld_h");
        issue(1'b0, 3'd6, 32'h202, 32'h0, 32'h00008001, 1'b0, "mis_ld_hu_ok");
`else
        issue(1'b1, 3'd3, 32'h103, 32'h12345678, 32'h0, 1'b0, "unal_st_w");
        issue(1'b0, 3'd3, 32'h100, 32'h0, 32'h12345678, 1'b0, "unal_ld_w");
        issue(1'b0, 3'd2, 32'h203, 32'h0, 32'hFFFF8001, 1'b0, "unal_ld_h");
`endif
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_wrap();
        test_back_to_back();
        test_latency3();
        test_reset_mid();
        test_misalign();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_port_responder.md
Name: mem_port_responder

Overview:
- Memory-side responder for the core's MemPortIo request/response protocol; serves one imem or dmem port from a private word-organised scratchpad.
- Accepts one request at a time through a valid/ready handshake and performs byte/half/word stores with lane masking.
- Loads return sign- or zero-extended data after a fixed, parameterised latency.
- Instantiated once per port beside core in the top-level tile.

Parameters:
- DEPTH_WORDS, 4096, scratchpad size in 32-bit words; power of two, ≥ 2.
- LATENCY, 1, cycles from the accepting edge to resp_valid; ≥ 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request this cycle.
- req_addr  in  32  byte address.
- req_data  in  32  store data, right-aligned.
- req_fcn  in  1  0 = read (M_XRD), 1 = write (M_XWR).
- req_typ  in  3  1 = MT_B, 2 = MT_H, 3 = MT_W, 5 = MT_BU, 6 = MT_HU.
- resp_valid  out  1  one-cycle response strobe; no backpressure.
- resp_data  out  32  load result; 0 for stores.

Behaviour:
- Reset (async, rst high): state IDLE, count 0, resp_valid 0, resp_data 0. Scratchpad contents are not reset.
- Reset mid-operation: any pending request is dropped and no response is issued. A store already accepted before reset remains written.
- FSM states IDLE, BUSY, RESP. req_ready = 1 in IDLE and RESP, 0 in BUSY (decoded from state).
- A request is accepted on a rising edge where req_valid & req_ready.
  - On accept: if LATENCY = 1, next state is RESP; otherwise next state is BUSY and count loads LATENCY-2.
- BUSY: decrement count each cycle; at 0, go to RESP.
- RESP: resp_valid = 1 for exactly this cycle. Next state is IDLE, unless a new request is accepted in the same cycle, in which case the accept rules apply (LATENCY = 1 gives back-to-back responses, one per cycle).
- Index: req_addr[log2(DEPTH_WORDS)+1:2]. Upper address bits are ignored, so addresses wrap modulo 4·DEPTH_WORDS.
- Store (committed on the accepting edge):
  - MT_B/MT_BU write lane addr[1:0] with req_data[7:0].
  - MT_H/MT_HU write lanes {addr[1],0} and {addr[1],1} with req_data[15:0]. addr[0] is ignored.
  - MT_W writes all lanes. addr[1:0] are ignored.
- Load: the word is read on the accepting edge and registered. Lane extraction uses the same rules as stores. MT_B/MT_H sign-extend; MT_BU/MT_HU zero-extend.
- Illegal typ (0, 4, 7): treated as MT_W.
- Read-after-write: a load accepted on the edge after a store to the same word returns the new data.
- A load and a store are never in flight together (single outstanding request).
- resp_data holds its last value between responses.

Optional Feature:
- Macro MEM_MISALIGN_CHECK_EN.
- Defined: adds output resp_misaligned (1 bit, reset 0), asserted with resp_valid when the request is misaligned (half with addr[0]=1, word with addr[1:0]≠0).
  - Misaligned stores are suppressed (no lanes written).
  - Misaligned loads return resp_data = 0.
  - resp_misaligned = 0 whenever resp_valid = 0.
- Undefined: no extra port; misaligned low bits are ignored as above.

Test Plan:
- Reset then idle → req_ready=1, resp_valid=0, resp_data=0; assert rst mid-BUSY (LATENCY=3) → no resp_valid afterwards, req_ready=1 next cycle.
- MT_W store 0xDEADBEEF @0x100, then MT_W load @0x100 → resp_data=0xDEADBEEF; with LATENCY=1, resp_valid is high in the cycle after each accept.
- MT_B store 0x80 @0x101 over word 0x00000000, then MT_B load @0x101 → 0xFFFFFF80; MT_BU load @0x101 → 0x00000080; MT_W load @0x100 → 0x00008000.
- MT_H store 0x8001 @0x202, then MT_H load @0x202 → 0xFFFF8001; MT_HU → 0x00008001; lanes 0–1 are unchanged.
- LATENCY=3, req_valid held high with 4 loads → resp_valid 3 cycles after each accept, req_ready low in BUSY; LATENCY=1 gives 4 responses in 4 consecutive cycles.
- MEM_MISALIGN_CHECK_EN defined: MT_W store 0x12345678 @0x103 → resp_misaligned=1, memory unchanged; MT_W load @0x103 → resp_data=0, resp_misaligned=1. Undefined: the same store writes word 0x100.
